// File: rtl/seed_mode_ctrl_if.sv
// Stream, init and cipher-core handshake bundle for seed_mode_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface seed_mode_ctrl_if #(
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
);
  logic               i_fInit;
  logic [1:0]         i_Mode;
  logic               i_Dec;
  logic [BLOCK_W-1:0] i_Key;
  logic [BLOCK_W-1:0] i_IV;
  logic [BLOCK_W-1:0] i_Text;
  logic               i_fValid;
  logic               o_fReady;
  logic [BLOCK_W-1:0] o_Text;
  logic               o_fValid;
  logic               i_OutReady;
  logic [CNT_W-1:0]   o_BlkCnt;
  logic [BLOCK_W-1:0] o_CoreText;
  logic [BLOCK_W-1:0] o_CoreKey;
  logic               o_CoreDec;
  logic               o_CoreStart;
  logic [BLOCK_W-1:0] i_CoreText;
  logic               i_CoreDone;

  modport slave (
    input  i_fInit, i_Mode, i_Dec, i_Key, i_IV, i_Text, i_fValid, i_OutReady,
           i_CoreText, i_CoreDone,
    output o_fReady, o_Text, o_fValid, o_BlkCnt, o_CoreText, o_CoreKey,
           o_CoreDec, o_CoreStart
  );

  modport master (
    output i_fInit, i_Mode, i_Dec, i_Key, i_IV, i_Text, i_fValid, i_OutReady,
           i_CoreText, i_CoreDone,
    input  o_fReady, o_Text, o_fValid, o_BlkCnt, o_CoreText, o_CoreKey,
           o_CoreDec, o_CoreStart
  );
endinterface

// File: rtl/seed_mode_ctrl.sv
// ECB/CBC/CTR mode-of-operation controller wrapped around one iterative
// block-cipher core; owns the chaining register and all stream handshakes.
module seed_mode_ctrl #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  seed_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_START,
    ST_BUSY,
    ST_OUT
  } state_t;

  localparam logic [1:0] MODE_ECB = 2'd0;
  localparam logic [1:0] MODE_CBC = 2'd1;
  localparam logic [1:0] MODE_CTR = 2'd2;

  // Low CTR_W bits form the counter; the upper part is a fixed nonce.
  localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_W);

  function automatic logic [BLOCK_W-1:0] ctr_next(input logic [BLOCK_W-1:0] c);
    logic [BLOCK_W-1:0] inc;
    inc = c + BLOCK_W'(1);
    return (c & ~CTR_MASK) | (inc & CTR_MASK);
  endfunction

  state_t             state;
  logic [1:0]         mode_q;
  logic               dec_q;
  logic [BLOCK_W-1:0] key_q;
  logic [BLOCK_W-1:0] chain_q;
  logic [BLOCK_W-1:0] in_q;
  logic [BLOCK_W-1:0] text_q;
  logic [BLOCK_W-1:0] core_text_q;
  logic               core_dec_q;
  logic               core_start_q;
  logic               valid_q;
  logic [CNT_W-1:0]   blk_cnt_q;

  logic               ready;
  logic               init_ok;
  logic               accept;
  logic [BLOCK_W-1:0] core_in_nxt;
  logic               core_dec_nxt;
  logic [BLOCK_W-1:0] out_nxt;
  logic [BLOCK_W-1:0] chain_nxt;

  // Init wins over a simultaneous input block, so ready drops while init is up.
  assign init_ok = bus.i_fInit & ((state == ST_IDLE) | (state == ST_READY));
  assign ready   = (state == ST_READY) & ~bus.i_fInit;
  assign accept  = ready & bus.i_fValid;

  always_comb begin
    core_in_nxt  = bus.i_Text;
    core_dec_nxt = dec_q;
    case (mode_q)
      MODE_CBC: begin
        core_in_nxt  = dec_q ? bus.i_Text : (bus.i_Text ^ chain_q);
        core_dec_nxt = dec_q;
      end
      MODE_CTR: begin
        core_in_nxt  = chain_q;
        core_dec_nxt = 1'b0;
      end
      default: begin
        core_in_nxt  = bus.i_Text;
        core_dec_nxt = dec_q;
      end
    endcase
  end

  always_comb begin
    out_nxt   = bus.i_CoreText;
    chain_nxt = chain_q;
    case (mode_q)
      MODE_CBC: begin
        if (dec_q) begin
          out_nxt   = bus.i_CoreText ^ chain_q;
          chain_nxt = in_q;
        end else begin
          out_nxt   = bus.i_CoreText;
          chain_nxt = bus.i_CoreText;
        end
      end
      MODE_CTR: begin
        out_nxt   = bus.i_CoreText ^ in_q;
        chain_nxt = ctr_next(chain_q);
      end
      default: begin
        out_nxt   = bus.i_CoreText;
        chain_nxt = chain_q;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_ECB;
      dec_q        <= 1'b0;
      key_q        <= '0;
      chain_q      <= '0;
      in_q         <= '0;
      text_q       <= '0;
      core_text_q  <= '0;
      core_dec_q   <= 1'b0;
      core_start_q <= 1'b0;
      valid_q      <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      core_start_q <= 1'b0;
      if (init_ok) begin
        state     <= ST_READY;
        mode_q    <= (bus.i_Mode == 2'd3) ? MODE_ECB : bus.i_Mode;
        dec_q     <= bus.i_Dec;
        key_q     <= bus.i_Key;
        chain_q   <= bus.i_IV;
        blk_cnt_q <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_READY: begin
            if (accept) begin
              in_q         <= bus.i_Text;
              core_text_q  <= core_in_nxt;
              core_dec_q   <= core_dec_nxt;
              core_start_q <= 1'b1;
              state        <= ST_START;
            end
          end
          ST_START: state <= ST_BUSY;
          // Chain state and block count advance only when the core result lands.
          ST_BUSY: begin
            if (bus.i_CoreDone) begin
              text_q    <= out_nxt;
              chain_q   <= chain_nxt;
              valid_q   <= 1'b1;
              blk_cnt_q <= blk_cnt_q + CNT_W'(1);
              state     <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (bus.i_OutReady) begin
              valid_q <= 1'b0;
              state   <= ST_READY;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_fReady    = ready;
  assign bus.o_Text      = text_q;
  assign bus.o_fValid    = valid_q;
  assign bus.o_BlkCnt    = blk_cnt_q;
  assign bus.o_CoreText  = core_text_q;
  assign bus.o_CoreKey   = key_q;
  assign bus.o_CoreDec   = core_dec_q;
  assign bus.o_CoreStart = core_start_q;

endmodule

// File: tb/tb_seed_mode_ctrl.sv
// Bench for seed_mode_ctrl: XOR stub cipher core, directed mode vectors,
// then randomized traffic against a block-level reference model.
module tb_seed_mode_ctrl;
  localparam int BW = 128;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seed_mode_ctrl_if #(.BLOCK_W(BW), .CNT_W(CW)) bus ();

  seed_mode_ctrl #(.BLOCK_W(BW), .CTR_W(32), .CNT_W(CW)) dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus)
  );

  // Stub core: result = text ^ key, done stub_lat cycles after start is seen.
  logic          stub_done = 1'b0;
  logic          spur_done = 1'b0;
  logic [BW-1:0] stub_res  = '0;
  logic [BW-1:0] spur_res  = '0;
  int            stub_lat  = 2;

  assign bus.i_CoreDone = stub_done | spur_done;
  assign bus.i_CoreText = spur_done ? spur_res : stub_res;

  initial begin
    logic [BW-1:0] res;
    forever begin
      @(negedge clk);
      if (bus.o_CoreStart === 1'b1) begin
        res = bus.o_CoreText ^ bus.o_CoreKey;
        repeat (stub_lat) @(negedge clk);
        stub_res  = res;
        stub_done = 1'b1;
        @(negedge clk);
        stub_done = 1'b0;
        stub_res  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [BW-1:0] m_key, m_C;
  int            m_mode;
  logic          m_dec;
  logic [CW-1:0] m_cnt;
  logic [BW-1:0] last_out, last_core;

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block through the mode equations, using the stub cipher E(x)=x^K.
  task automatic model_step(input logic [BW-1:0] p, output logic [BW-1:0] cin,
                            output logic cdec, output logic [BW-1:0] out);
    case (m_mode)
      1: begin
        if (m_dec) begin
          cin = p; cdec = 1'b1; out = (p ^ m_key) ^ m_C; m_C = p;
        end else begin
          cin = p ^ m_C; cdec = 1'b0; out = cin ^ m_key; m_C = out;
        end
      end
      2: begin
        cin = m_C; cdec = 1'b0; out = (m_C ^ m_key) ^ p;
        m_C = {m_C[BW-1:32], m_C[31:0] + 32'd1};
      end
      default: begin
        cin = p; cdec = m_dec; out = p ^ m_key;
      end
    endcase
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic do_init(input int mode, input logic dec, input logic [BW-1:0] key,
                         input logic [BW-1:0] iv);
    bus.i_fInit = 1'b1; bus.i_Mode = mode[1:0]; bus.i_Dec = dec;
    bus.i_Key = key; bus.i_IV = iv;
    @(negedge clk);
    bus.i_fInit = 1'b0;
    m_mode = mode; m_dec = dec; m_key = key; m_C = iv; m_cnt = '0;
    chk("init_key", bus.o_CoreKey, key);
    chk("init_cnt", bus.o_BlkCnt, '0);
  endtask

  task automatic send_block(input logic [BW-1:0] p, input int bp, input bit spur);
    logic [BW-1:0] exp_in, exp_out;
    logic          exp_dec;
    int            w;
    model_step(p, exp_in, exp_dec, exp_out);
    w = 0;
    while (bus.o_fReady !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("ready_wait", {127'b0, (w < 20)}, 1);
    bus.i_Text = p; bus.i_fValid = 1'b1;
    @(negedge clk);
    bus.i_fValid = 1'b0; bus.i_Text = rnd128();
    chk("core_start", bus.o_CoreStart, 1);
    chk("core_text", bus.o_CoreText, exp_in);
    chk("core_dec", bus.o_CoreDec, exp_dec);
    last_core = bus.o_CoreText;
    @(negedge clk);
    chk("start_one_cycle", bus.o_CoreStart, 0);
    chk("core_text_hold", bus.o_CoreText, exp_in);
    w = 0;
    while (bus.o_fValid !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("valid_wait", {127'b0, (w < 50)}, 1);
    chk("out_text", bus.o_Text, exp_out);
    chk("blk_cnt", bus.o_BlkCnt, m_cnt);
    last_out = bus.o_Text;
    for (int i = 0; i < bp; i++) begin
      if (spur && i == 0) begin spur_res = rnd128(); spur_done = 1'b1; end
      @(negedge clk);
      spur_done = 1'b0;
      chk("bp_valid", bus.o_fValid, 1);
      chk("bp_text", bus.o_Text, exp_out);
      chk("bp_ready", bus.o_fReady, 0);
      chk("bp_cnt", bus.o_BlkCnt, m_cnt);
    end
    bus.i_OutReady = 1'b1;
    @(negedge clk);
    bus.i_OutReady = 1'b0;
    chk("rel_valid", bus.o_fValid, 0);
    chk("rel_ready", bus.o_fReady, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_text"}, bus.o_Text, '0);
    chk({tag, "_ctext"}, bus.o_CoreText, '0);
    chk({tag, "_ckey"}, bus.o_CoreKey, '0);
    chk({tag, "_valid"}, bus.o_fValid, 0);
    chk({tag, "_ready"}, bus.o_fReady, 0);
    chk({tag, "_start"}, bus.o_CoreStart, 0);
    chk({tag, "_cdec"}, bus.o_CoreDec, 0);
    chk({tag, "_cnt"}, bus.o_BlkCnt, '0);
  endtask

  localparam logic [BW-1:0] K = 128'h0F;

  initial begin
    logic any_v, any_s;
    bus.i_fInit = 0; bus.i_Mode = 0; bus.i_Dec = 0; bus.i_Key = '0; bus.i_IV = '0;
    bus.i_Text = '0; bus.i_fValid = 0; bus.i_OutReady = 0;
    m_key = '0; m_C = '0; m_mode = 0; m_dec = 0; m_cnt = '0;
    last_out = '0; last_core = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1; bus.i_fValid = 1'b1;
    any_s = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", bus.o_fReady, 0);
      any_s |= bus.o_CoreStart;
    end
    chk("idle_no_start", any_s, 0);
    bus.i_fValid = 1'b0;

    // ECB encrypt
    do_init(0, 1'b0, K, '0);
    send_block(128'h01, 0, 0);
    chk("ecb_out", last_out, 128'h0E);
    chk("ecb_cnt", bus.o_BlkCnt, 1);

    // CBC encrypt, second block under 5 cycles of backpressure
    do_init(1, 1'b0, K, 128'h10);
    send_block(128'h01, 0, 0);
    chk("cbce_core1", last_core, 128'h11);
    chk("cbce_out1", last_out, 128'h1E);
    send_block(128'h02, 5, 0);
    chk("cbce_core2", last_core, 128'h1C);
    chk("cbce_out2", last_out, 128'h13);

    // CBC decrypt
    do_init(1, 1'b1, K, 128'h10);
    send_block(128'h1E, 0, 0);
    chk("cbcd_out1", last_out, 128'h01);
    chk("cbcd_dec", bus.o_CoreDec, 1);
    send_block(128'h13, 1, 1);
    chk("cbcd_out2", last_out, 128'h02);

    // CTR with counter wrap, i_Dec ignored
    do_init(2, 1'b1, K, {96'h5, 32'hFFFFFFFF});
    send_block('0, 0, 0);
    chk("ctr_out1", last_out, {96'h5, 32'hFFFFFFF0});
    chk("ctr_dec1", bus.o_CoreDec, 0);
    send_block('0, 2, 1);
    chk("ctr_out2", last_out, {96'h5, 32'h0000000F});
    chk("ctr_dec2", bus.o_CoreDec, 0);

    // Init and valid together in READY
    bus.i_fInit = 1'b1; bus.i_fValid = 1'b1; bus.i_Mode = 2'd0; bus.i_Dec = 1'b0;
    bus.i_Key = K; bus.i_IV = '0; bus.i_Text = 128'h55;
    #1;
    chk("prio_ready", bus.o_fReady, 0);
    @(negedge clk);
    bus.i_fInit = 1'b0; bus.i_fValid = 1'b0;
    m_mode = 0; m_dec = 0; m_key = K; m_C = '0; m_cnt = '0;
    chk("prio_no_start", bus.o_CoreStart, 0);
    chk("prio_cnt", bus.o_BlkCnt, 0);
    @(negedge clk);
    chk("prio_no_start2", bus.o_CoreStart, 0);

    // Reset while BUSY, stub done arriving after release
    do_init(1, 1'b0, K, 128'h10);
    stub_lat = 5;
    bus.i_Text = 128'h01; bus.i_fValid = 1'b1;
    @(negedge clk);
    bus.i_fValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("busy_rst");
    @(negedge clk);
    rst_n = 1'b1; bus.i_fValid = 1'b1;
    any_v = 1'b0; any_s = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_v |= bus.o_fValid;
      any_s |= bus.o_CoreStart;
      chk("post_rst_ready", bus.o_fReady, 0);
    end
    bus.i_fValid = 1'b0;
    chk("post_rst_no_valid", any_v, 0);
    chk("post_rst_no_start", any_s, 0);
    chk("post_rst_cnt", bus.o_BlkCnt, 0);
    m_C = '0; m_cnt = '0;

    // Randomized traffic
    do_init($urandom_range(0, 3), 1'($urandom), rnd128(), rnd128());
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        do_init($urandom_range(0, 3), 1'($urandom), rnd128(), rnd128());
      stub_lat = $urandom_range(1, 4);
      send_block(rnd128(), $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
